// File: rtl/rt_ibex_pcs_pkg.sv
// Shared types and constants for the preemptive-context-save path.
// Keeps the LIFO and the restore sequencer in agreement on snapshot layout.
package rt_ibex_pcs_pkg;

  localparam int unsigned PcsNrSavedRegs = 9;
  localparam int unsigned PcsAddrWidth   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } restore_state_t;

  // Slot 0 is x1; the remaining slots hold the caller-saved temporaries/args.
  localparam logic [PcsNrSavedRegs-1:0][PcsAddrWidth-1:0]
    PcsDefaultRegMap = {
      5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
      5'd7,  5'd6,  5'd5,  5'd1
    };

endpackage

// File: rtl/rt_ibex_pcs_restore_seq.sv
// Restore sequencer: captures a popped register snapshot and writes it
// back through the shared RF write port, one register per granted cycle.
module rt_ibex_pcs_restore_seq
  import rt_ibex_pcs_pkg::*;
#(
  parameter int unsigned NrSavedRegs = PcsNrSavedRegs,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = PcsAddrWidth,
  parameter logic [NrSavedRegs-1:0][AddrWidth-1:0]
    RegAddrMap = PcsDefaultRegMap
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  output logic                                rf_we_o,
  output logic [AddrWidth-1:0]                rf_waddr_o,
  output logic [DataWidth-1:0]                rf_wdata_o,
  input  logic                                rf_wgnt_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                overrun_o
);

  localparam int unsigned IdxW =
    (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NrSavedRegs - 1);

  restore_state_t state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] buf_q, buf_d;

  logic [AddrWidth-1:0] slot_addr;
  logic                 slot_skip;

  // Next-state, index advance, snapshot capture and RF request outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    done_o     = 1'b0;
    overrun_o  = 1'b0;
    slot_addr  = RegAddrMap[idx_q];
    slot_skip  = (slot_addr == '0);

    unique case (state_q)
      IDLE: begin
        if (restore_en_i) begin
          buf_d   = restore_data_i;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        overrun_o = restore_en_i;
        if (!slot_skip) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = slot_addr;
          rf_wdata_o = buf_q[idx_q];
        end
        // x0 slots retire without using the port.
        if (slot_skip || rf_wgnt_i) begin
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_o    = 1'b1;
        overrun_o = restore_en_i;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // State, index and snapshot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_rt_ibex_pcs_restore_seq.sv
// Directed bench for the restore sequencer.
// Second instance uses a map with an x0 slot.
module tb_rt_ibex_pcs_restore_seq;

  logic clk = 1'b0;
  logic rst_ni;
  logic restore_en;
  logic [8:0][31:0] rdata;
  logic gnt;

  logic        we, busy, done, ovr;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic        s_we, s_busy, s_done, s_ovr;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [8:0][4:0] SkipMap = {
    5'd14, 5'd13, 5'd12, 5'd11, 5'd10,
    5'd0,  5'd6,  5'd5,  5'd1
  };

  int map [9] = '{1, 5, 6, 7, 10, 11, 12, 13, 14};

  always #5 clk = ~clk;

  rt_ibex_pcs_restore_seq dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .restore_en_i(restore_en), .restore_data_i(rdata),
    .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
    .rf_wgnt_i(gnt), .busy_o(busy), .done_o(done),
    .overrun_o(ovr)
  );

  rt_ibex_pcs_restore_seq #(.RegAddrMap(SkipMap)) dut_skip (
    .clk_i(clk), .rst_ni(rst_ni),
    .restore_en_i(restore_en), .restore_data_i(rdata),
    .rf_we_o(s_we), .rf_waddr_o(s_waddr), .rf_wdata_o(s_wdata),
    .rf_wgnt_i(gnt), .busy_o(s_busy), .done_o(s_done),
    .overrun_o(s_ovr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int i = 0; i < 9; i++) rdata[i] = base + 32'(i);
  endtask

  // Write check for the default-map instance.
  task automatic chk_wr(input string tag, input int slot,
                        input logic [31:0] base);
    chk({tag, "_we"}, 64'(we), 64'd1);
    chk({tag, "_addr"}, 64'(waddr), 64'(map[slot]));
    chk({tag, "_data"}, 64'(wdata), 64'(base + 32'(slot)));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Full-grant restore from cycle 0 to the done cycle inclusive,
  // returning positioned in the cycle after done.
  task automatic full_run(input string tag, input logic [31:0] base);
    gnt = 1'b1;
    set_data(base);
    restore_en = 1'b1;
    #1;
    chk({tag, "_c0_ovr"}, 64'(ovr), 64'd0);
    chk({tag, "_c0_we"}, 64'(we), 64'd0);
    cyc();
    restore_en = 1'b0;
    set_data(32'h0);
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk_wr(tag, c - 1, base);
      cyc();
    end
    #1;
    chk({tag, "_c10_done"}, 64'(done), 64'd1);
    chk({tag, "_c10_busy"}, 64'(busy), 64'd1);
    chk({tag, "_c10_we"}, 64'(we), 64'd0);
    cyc();
  endtask

  int s_writes;
  int s_x7;
  int slot;

  initial begin
    rst_ni = 1'b0;
    restore_en = 1'b0;
    gnt = 1'b0;
    rdata = '0;
    #12;
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_addr", 64'(waddr), 64'd0);
    chk("rst_data", 64'(wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovr", 64'(ovr), 64'd0);
    rst_ni = 1'b1;
    cyc();
    cyc();

    full_run("full", 32'hA000_0000);
    #1;
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    full_run("b2b", 32'hB000_0000);
    #1;
    chk("b2b_end_busy", 64'(busy), 64'd0);

    // Grant withheld in cycles 2-4: slot 1 holds for three extra cycles.
    gnt = 1'b1;
    set_data(32'hC000_0000);
    restore_en = 1'b1;
    cyc();
    restore_en = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      gnt = !(c >= 2 && c <= 4);
      slot = (c <= 1) ? 0 : (c <= 5) ? 1 : c - 4;
      #1;
      chk_wr("stall", slot, 32'hC000_0000);
      cyc();
    end
    gnt = 1'b1;
    #1;
    chk("stall_done", 64'(done), 64'd1);
    cyc();

    for (int i = 0; i < 12; i++) cyc();

    // x0 slot in the skip-map instance.
    set_data(32'hD000_0000);
    restore_en = 1'b1;
    cyc();
    restore_en = 1'b0;
    s_writes = 0;
    s_x7 = 0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (s_we) s_writes++;
      if (s_we && s_waddr == 5'd7) s_x7++;
      if (c == 4) begin
        chk("skip_c4_we", 64'(s_we), 64'd0);
        chk("skip_c4_addr", 64'(s_waddr), 64'd0);
        chk("skip_c4_data", 64'(s_wdata), 64'd0);
      end else begin
        chk("skip_addr", 64'(s_waddr), 64'(map[c - 1]));
        chk("skip_data", 64'(s_wdata), 64'(32'hD000_0000 + 32'(c - 1)));
      end
      cyc();
    end
    #1;
    chk("skip_done", 64'(s_done), 64'd1);
    chk("skip_writes", 64'(s_writes), 64'd8);
    chk("skip_x7", 64'(s_x7), 64'd0);
    cyc();
    for (int i = 0; i < 12; i++) cyc();

    // Overrun: second request in cycle 5 is ignored.
    gnt = 1'b1;
    set_data(32'hE000_0000);
    restore_en = 1'b1;
    cyc();
    restore_en = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c == 5) begin
        set_data(32'hF000_0000);
        restore_en = 1'b1;
      end
      #1;
      chk("ovr_pulse", 64'(ovr), (c == 5) ? 64'd1 : 64'd0);
      chk_wr("ovr", c - 1, 32'hE000_0000);
      cyc();
      restore_en = 1'b0;
    end
    #1;
    chk("ovr_done", 64'(done), 64'd1);
    cyc();
    #1;
    chk("ovr_idle", 64'(busy), 64'd0);

    // Asynchronous reset in cycle 4.
    set_data(32'h1111_0000);
    restore_en = 1'b1;
    cyc();
    restore_en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk_wr("mrst", c - 1, 32'h1111_0000);
      cyc();
    end
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mrst_we", 64'(we), 64'd0);
    chk("mrst_addr", 64'(waddr), 64'd0);
    chk("mrst_data", 64'(wdata), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    #1;
    chk("mrst_idle", 64'(busy), 64'd0);
    full_run("post", 32'h1234_0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
